// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit mid-sampling, LSB-first
// data capture, framing-error/break detection, one-cycle valid strobe.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       uart_rx_in,
  output logic [7:0] uart_dat,
  output logic       uart_dv,
  output logic       frame_err,
  output logic       rx_busy
);

  // CLKS_PER_BIT must be >= 4 for the half-bit start sample to be meaningful.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dat_q, dat_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;
  logic             rx_s;

  assign rx_s = sync2_q;

  // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      dat_q     <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      dat_q     <= dat_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    dat_d     = dat_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            dat_d   = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        // Held-low line: wait for release so a break yields one error, not a bogus frame.
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign uart_dat  = dat_q;
  assign uart_dv   = dv_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk_100;
  logic       rst_n;
  logic       uart_rx_in;
  logic [7:0] uart_dat;
  logic       uart_dv;
  logic       frame_err;
  logic       rx_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitor state, updated on the falling edge away from the active edge.
  int         cyc       = 0;
  int         dv_cnt    = 0;
  int         fe_cnt    = 0;
  int         busy_cnt  = 0;
  int         dv_run    = 0;
  int         fe_run    = 0;
  int         dv_max_w  = 0;
  int         fe_max_w  = 0;
  int         adj_cnt   = 0;
  int         dv_t_prev = 0;
  int         dv_t_last = 0;
  logic [7:0] dat_prev  = 8'h00;
  logic [7:0] dat_last  = 8'h00;
  logic       dv_d1     = 1'b0;
  logic       fe_d1     = 1'b0;

  uart_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .uart_rx_in(uart_rx_in),
    .uart_dat  (uart_dat),
    .uart_dv   (uart_dv),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  always @(negedge clk_100) begin
    cyc = cyc + 1;
    if (uart_dv) begin
      dv_cnt    = dv_cnt + 1;
      dv_t_prev = dv_t_last;
      dv_t_last = cyc;
      dat_prev  = dat_last;
      dat_last  = uart_dat;
      dv_run    = dv_run + 1;
      if (dv_run > dv_max_w) dv_max_w = dv_run;
    end else begin
      dv_run = 0;
    end
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_run = fe_run + 1;
      if (fe_run > fe_max_w) fe_max_w = fe_run;
    end else begin
      fe_run = 0;
    end
    if (rx_busy) busy_cnt = busy_cnt + 1;
    if ((uart_dv && frame_err) || (uart_dv && fe_d1) || (frame_err && dv_d1))
      adj_cnt = adj_cnt + 1;
    dv_d1 = uart_dv;
    fe_d1 = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic send_bit(input logic b);
    uart_rx_in = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  int dv0, fe0, bz0;

  initial begin
    rst_n      = 1'b0;
    uart_rx_in = 1'b1;

    // Line activity during reset must be ignored.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_100);
      uart_rx_in = ~uart_rx_in;
    end
    idle(1);
    check("rst_dv",   {31'd0, uart_dv},   32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, rx_busy},   32'd0);
    check("rst_dat",  {24'd0, uart_dat},  32'h00);
    check("rst_dvcnt", dv_cnt, 0);

    uart_rx_in = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check("post_rst_busy", {31'd0, rx_busy},  32'd0);
    check("post_rst_dat",  {24'd0, uart_dat}, 32'h00);
    check("post_rst_evts", dv_cnt + fe_cnt,   0);

    // Single good frame.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_dv",   dv_cnt - dv0, 1);
    check("a5_cap",  {24'd0, dat_last}, 32'hA5);
    check("a5_ferr", fe_cnt - fe0, 0);
    idle(200);
    check("a5_hold", {24'd0, uart_dat}, 32'hA5);

    // Back-to-back frames; identical per-frame timing puts the strobes one frame apart.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h41, 1'b1);
    send_frame(8'h0D, 1'b1);
    idle(20);
    check("b2b_dv",    dv_cnt - dv0, 2);
    check("b2b_first", {24'd0, dat_prev}, 32'h41);
    check("b2b_second",{24'd0, dat_last}, 32'h0D);
    check("b2b_gap",   dv_t_last - dv_t_prev, 10 * CPB);
    check("b2b_ferr",  fe_cnt - fe0, 0);

    // Short low glitch on an idle line.
    dv0 = dv_cnt; fe0 = fe_cnt; bz0 = busy_cnt;
    uart_rx_in = 1'b0;
    idle(3);
    uart_rx_in = 1'b1;
    idle(30);
    check("gl_busy_seen", {31'd0, (busy_cnt - bz0) > 0}, 32'd1);
    check("gl_busy_end",  {31'd0, rx_busy}, 32'd0);
    check("gl_dv",        dv_cnt - dv0, 0);
    check("gl_ferr",      fe_cnt - fe0, 0);

    // Bad stop bit followed by a held break, then recovery.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(50);
    uart_rx_in = 1'b1;
    idle(20);
    check("brk_ferr", fe_cnt - fe0, 1);
    check("brk_dv",   dv_cnt - dv0, 0);
    check("brk_dat",  {24'd0, uart_dat}, 32'h0D);
    check("brk_busy", {31'd0, rx_busy}, 32'd0);
    dv0 = dv_cnt;
    send_frame(8'h33, 1'b1);
    idle(20);
    check("rec_dv",  dv_cnt - dv0, 1);
    check("rec_dat", {24'd0, uart_dat}, 32'h33);

    // Reset in the middle of data bit 4 of 0xFF.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle(5);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(60);
    check("abort_dv",   dv_cnt - dv0, 0);
    check("abort_ferr", fe_cnt - fe0, 0);
    check("abort_dat",  {24'd0, uart_dat}, 32'h00);
    check("abort_busy", {31'd0, rx_busy}, 32'd0);
    dv0 = dv_cnt;
    send_frame(8'h12, 1'b1);
    idle(20);
    check("post_abort_dv",  dv_cnt - dv0, 1);
    check("post_abort_dat", {24'd0, uart_dat}, 32'h12);

    check("dv_width",   dv_max_w, 1);
    check("ferr_width", fe_max_w, 1);
    check("dv_ferr_excl", adj_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver on the 100 MHz system clock.
- Converts the asynchronous serial line into a byte plus a one-cycle valid strobe (uart_dat / uart_dv).
- Sits directly upstream of the UART-to-keyboard arbiter, which turns each received byte into a PS/2-clock write enable for the unified terminal.
- Also reports framing errors and line activity for debug LEDs.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (10416 at defaults), clocks per bit period. Derived localparam; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), clocks from start-edge detect to start-bit mid-sample.

Ports:
- clk_100  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx_in  in  1  raw serial line; idles high; asynchronous to clk_100.
- uart_dat  out  8  last correctly framed byte; held until the next good frame.
- uart_dv  out  1  one-cycle pulse: uart_dat updated this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - uart_dat=8'h00, uart_dv=0, frame_err=0, rx_busy=0.
  - Both synchronizer flops=1, FSM=IDLE, bit counter=0, clock counter=0.
  - Reset mid-frame discards the partial byte; no dv or frame_err pulse is generated.
- Synchronizer: uart_rx_in passes through 2 flops, producing rx_s. All decisions use rx_s, so the line-to-rx_s latency is 2 cycles.
- Clock counter (clk_cnt) is wide enough for CLKS_PER_BIT-1. It clears on every state change.
- FSM states and transitions:
  - IDLE: if rx_s==0, go to START.
  - START: count to HALF_BIT-1, then sample rx_s.
    - rx_s==0: go to DATA with bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no output.
  - DATA: count to CLKS_PER_BIT-1, then shift rx_s into bit position bit_idx (LSB first).
    - After bit_idx==7, go to STOP; otherwise increment bit_idx.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - rx_s==1: uart_dat <= shift register, uart_dv=1 for exactly one cycle, go to IDLE.
    - rx_s==0: frame_err=1 for exactly one cycle, uart_dat unchanged, go to BRK.
  - BRK: wait until rx_s==1, then go to IDLE. A held-low break line therefore produces exactly one frame_err and never a spurious frame.
- uart_dv and frame_err are mutually exclusive and never asserted in consecutive cycles for one frame.
- Output timing: uart_dv rises on the clock edge after the stop-bit mid-sample. Back-to-back frames are accepted; IDLE can detect the next start bit on the cycle after returning.
- rx_busy = (state != IDLE), registered together with the state.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so CLKS_PER_BIT=10 and HALF_BIT=5):
- Hold rst_n low, toggle uart_rx_in -> all outputs stay 0; release reset with line high -> outputs remain 0, rx_busy=0.
- Send 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single uart_dv pulse with uart_dat=8'hA5. uart_dat is still 8'hA5 200 cycles later.
- Send 8'h41 then 8'h0D back-to-back with no idle gap -> two uart_dv pulses about 100 cycles apart, carrying 8'h41 then 8'h0D. frame_err never fires.
- Drive a 3-cycle low glitch on the idle line -> rx_busy pulses, FSM returns to IDLE, no uart_dv, no frame_err.
- Send 8'h55 with stop bit 0, hold line low 50 cycles, then release -> one frame_err pulse, no uart_dv, uart_dat keeps its previous value. The next good frame 8'h33 is received correctly.
- Assert rst_n low at data bit 4 of 8'hFF, release, then send 8'h12 -> no output for the aborted frame; uart_dv fires with uart_dat=8'h12.
